// File: rtl/cmd_frame_host_pkg.sv
// Shared definitions for the host-side UART command initiator:
// frame opcodes, command type encoding, FSM states and per-type frame/response lengths.
package cmd_frame_host_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    TYPE_WR      = 2'd0,
    TYPE_RD      = 2'd1,
    TYPE_ALU_OP  = 2'd2,
    TYPE_ALU_NOP = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP,
    ST_FIN
  } state_e;

  function automatic logic [2:0] frame_len(input cmd_type_e t);
    case (t)
      TYPE_WR:     frame_len = 3'd3;
      TYPE_RD:     frame_len = 3'd2;
      TYPE_ALU_OP: frame_len = 3'd4;
      default:     frame_len = 3'd2;
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(input cmd_type_e t);
    case (t)
      TYPE_WR: rsp_len = 2'd0;
      TYPE_RD: rsp_len = 2'd1;
      default: rsp_len = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/cmd_frame_host.sv
// Serializes one register/ALU command into UART frame bytes and assembles the response.
// Define CMD_HOST_TIMEOUT_EN to bound the response wait to TimeoutCycles clocks.
module cmd_frame_host
  import cmd_frame_host_pkg::*;
#(
  parameter int BusWidth      = 8,
  parameter int FuncWidth     = 4,
  parameter int AddWidth      = 4,
  parameter int TimeoutCycles = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VLD,
  input  logic [1:0]            CMD_TYPE,
  input  logic [AddWidth-1:0]   CMD_ADDR,
  input  logic [BusWidth-1:0]   CMD_DATA,
  input  logic [BusWidth-1:0]   CMD_OPA,
  input  logic [BusWidth-1:0]   CMD_OPB,
  input  logic [FuncWidth-1:0]  CMD_FUN,
  output logic                  CMD_BUSY,
  output logic [BusWidth-1:0]   TX_P_Data,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  input  logic [BusWidth-1:0]   RX_P_Data,
  input  logic                  RX_D_VLD,
  output logic [2*BusWidth-1:0] RSP_DATA,
  output logic                  DONE,
  output logic                  TIMEOUT
);

  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 2");
  end

  state_e                 state_q, state_d;
  cmd_type_e              type_q, type_d;
  logic [AddWidth-1:0]    addr_q, addr_d;
  logic [BusWidth-1:0]    data_q, data_d, opa_q, opa_d, opb_q, opb_d;
  logic [FuncWidth-1:0]   fun_q, fun_d;
  logic [2:0]             tx_idx_q, tx_idx_d;
  logic [1:0]             rx_idx_q, rx_idx_d;
  logic [2*BusWidth-1:0]  rsp_q, rsp_d;
  logic [BusWidth-1:0]    tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   to_hit;
  logic                   rx_last;

`ifdef CMD_HOST_TIMEOUT_EN
  localparam int unsigned TW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Held at zero outside RESP, so it starts from zero on every RESP entry.
  always_comb begin
    tcnt_d = '0;
    if (state_q == ST_RESP) tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end

  assign to_hit = (state_q == ST_RESP) && (tcnt_q == TLast);
`else
  assign to_hit = 1'b0;
`endif

  function automatic logic [BusWidth-1:0] frame_byte(input cmd_type_e t, input logic [2:0] i);
    logic [BusWidth-1:0] b;
    b = '0;
    case (t)
      TYPE_WR:
        case (i)
          3'd0:    b = BusWidth'(CMD_WR);
          3'd1:    b = BusWidth'(addr_q);
          default: b = data_q;
        endcase
      TYPE_RD:     b = (i == 3'd0) ? BusWidth'(CMD_RD) : BusWidth'(addr_q);
      TYPE_ALU_OP:
        case (i)
          3'd0:    b = BusWidth'(CMD_ALU_OP);
          3'd1:    b = opa_q;
          3'd2:    b = opb_q;
          default: b = BusWidth'(fun_q);
        endcase
      default:     b = (i == 3'd0) ? BusWidth'(CMD_ALU_NOP) : BusWidth'(fun_q);
    endcase
    return b;
  endfunction

  assign rx_last = (rx_idx_q == (rsp_len(type_q) - 2'd1));

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    addr_d    = addr_q;
    data_d    = data_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    fun_d     = fun_q;
    tx_idx_d  = tx_idx_q;
    rx_idx_d  = rx_idx_q;
    rsp_d     = rsp_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VLD && !busy_q) begin
          type_d    = cmd_type_e'(CMD_TYPE);
          addr_d    = CMD_ADDR;
          data_d    = CMD_DATA;
          opa_d     = CMD_OPA;
          opb_d     = CMD_OPB;
          fun_d     = CMD_FUN;
          tx_idx_d  = '0;
          rsp_d     = '0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!TX_Busy) begin
          tx_vld_d  = 1'b1;
          tx_data_d = frame_byte(type_q, tx_idx_q);
          tx_idx_d  = tx_idx_q + 3'd1;
          state_d   = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: if (TX_Busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!TX_Busy) begin
          if (tx_idx_q < frame_len(type_q)) begin
            state_d = ST_SEND;
          end else if (rsp_len(type_q) == 2'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            rx_idx_d = '0;
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (RX_D_VLD) begin
          if (rx_idx_q == 2'd0) rsp_d[BusWidth-1:0]          = RX_P_Data;
          else                  rsp_d[2*BusWidth-1:BusWidth] = RX_P_Data;
          rx_idx_d = rx_idx_q + 2'd1;
        end
        // A final byte landing on the timeout cycle still counts as completion.
        if (RX_D_VLD && rx_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FIN;
        end else if (to_hit) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      type_q    <= TYPE_WR;
      addr_q    <= '0;
      data_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      fun_q     <= '0;
      tx_idx_q  <= '0;
      rx_idx_q  <= '0;
      rsp_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      fun_q     <= fun_d;
      tx_idx_q  <= tx_idx_d;
      rx_idx_q  <= rx_idx_d;
      rsp_q     <= rsp_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign CMD_BUSY  = busy_q;
  assign TX_P_Data = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign RSP_DATA  = rsp_q;
  assign DONE      = done_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: doc/cmd_frame_host.md
# cmd_frame_host

Host-side command initiator for the configurable system's UART register/ALU command protocol. It serializes one command at a time into frame bytes for a UART transmitter and collects the system's response bytes from a UART receiver. It pairs with the system controller's RX/TX command paths, sits in the bench and host-side glue on the same byte-parallel UART interfaces, and returns a single assembled result per command.

## Interface
- BusWidth, 8, frame byte / register data width
- FuncWidth, 4, ALU function code width
- AddWidth, 4, register address width
- TimeoutCycles, 4096, response timeout in CLK cycles; used only with the timeout feature
- CLK  in  1  single clock
- RST  in  1  reset: asynchronous, active-low
- CMD_VLD  in  1  command request
- CMD_TYPE  in  2  0 = reg write, 1 = reg read, 2 = ALU with operands, 3 = ALU without operands
- CMD_ADDR  in  AddWidth  register address
- CMD_DATA  in  BusWidth  write data
- CMD_OPA, CMD_OPB  in  BusWidth  ALU operands
- CMD_FUN  in  FuncWidth  ALU function
- CMD_BUSY  out  1  command in progress; high blocks acceptance
- TX_P_Data  out  BusWidth  byte to UART TX
- TX_D_VLD  out  1  one-cycle byte strobe
- TX_Busy  in  1  UART TX busy
- RX_P_Data  in  BusWidth  byte from UART RX
- RX_D_VLD  in  1  one-cycle received-byte strobe
- RSP_DATA  out  2*BusWidth  assembled response
- DONE  out  1  one-cycle completion pulse
- TIMEOUT  out  1  qualifies DONE: response timed out

## Operation
- Acceptance: CMD_VLD && !CMD_BUSY. All CMD_* fields are latched on acceptance. CMD_VLD while busy is ignored.
- Frames (first byte first):
  - write: 0xAA, addr, data
  - read: 0xBB, addr
  - ALU with operands: 0xCC, OPA, OPB, fun
  - ALU without operands: 0xDD, fun
- Addr and fun bytes are zero-extended to BusWidth.
- Expected response bytes: write 0, read 1, ALU 2 (low byte first, then high byte).
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO, RESP, FIN.
  - IDLE→SEND on acceptance.
  - SEND: if !TX_Busy, drive TX_D_VLD for one cycle with the current byte, then go to WAIT_HI.
  - WAIT_HI→WAIT_LO when TX_Busy=1.
  - WAIT_LO→SEND when TX_Busy=0 and bytes remain; otherwise go to RESP, or to FIN when 0 response bytes are expected.
  - RESP: each RX_D_VLD stores RX_P_Data into byte slot idx, then idx++. After the last expected byte, go to FIN.
  - FIN: DONE=1 for one cycle, then IDLE.
- Read response: RSP_DATA = {0, byte0}. ALU response: {byte1, byte0}. Write: RSP_DATA is cleared to 0 at acceptance.
- RX_D_VLD outside RESP is dropped, including bytes arriving during SEND or WAIT.
- RSP_DATA holds its value until the next acceptance.

## Timing
- Reset values: CMD_BUSY=0, TX_P_Data=0, TX_D_VLD=0, RSP_DATA=0, DONE=0, TIMEOUT=0. FSM=IDLE, all counters 0.
- Reset mid-operation aborts immediately. No DONE is produced for the aborted command.
- CMD_BUSY rises the cycle after acceptance and falls in the cycle DONE is high. A new command can be accepted the cycle after DONE.
- First TX_D_VLD appears no earlier than 2 cycles after acceptance (IDLE→SEND, SEND output).
- TX_P_Data is stable from the TX_D_VLD cycle until the next byte is loaded.
- RX_D_VLD arriving in the same cycle as the WAIT_LO→RESP transition is dropped. The system response cannot arrive that early, since it begins after the frame's last stop bit.
- DONE is asserted the cycle after the final response byte's RX_D_VLD.
- All outputs are registered.

## Configuration
- CMD_HOST_TIMEOUT_EN defined:
  - A counter clears on entering RESP and increments each cycle in RESP.
  - On reaching TimeoutCycles-1 without completion, go to FIN with TIMEOUT=1 alongside DONE. RSP_DATA holds the partial bytes received.
  - TIMEOUT is cleared on the next acceptance.
- Undefined: no counter, TIMEOUT tied 0, and RESP waits indefinitely.

## Structure
- Shared package holds:
  - opcode constants: CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD
  - the CMD_TYPE encoding
  - FSM state encoding
- Single module, no sub-module. Frame-byte selection is a function of the latched type and the byte index.

## Test plan
- Write addr=5, data=0x3C, TX model busy 10 cycles per byte → TX bytes AA,05,3C; DONE one cycle after last TX_Busy fall; RSP_DATA=0.
- Read addr=2, RX returns 0x7E → TX BB,02; RSP_DATA=0x007E, DONE=1, TIMEOUT=0.
- ALU with operands A=0x12, B=0x34, fun=0 → TX CC,12,34,00; RX 0x46 then 0x00 → RSP_DATA=0x0046.
- ALU without operands fun=3, RX 0xFF, 0x01; stray RX_D_VLD 0x55 injected during SEND → TX DD,03; RSP_DATA=0x01FF, stray byte ignored.
- CMD_VLD held high during busy, then RST pulled low mid-WAIT_HI → second request is not accepted while busy; on reset all outputs are 0 and no DONE occurs.
- With CMD_HOST_TIMEOUT_EN and TimeoutCycles=64: read, no RX bytes → DONE with TIMEOUT=1 exactly 64 cycles after entering RESP.
